// File: rtl/etx_arbiter_rr.sv
// N-channel eMesh transmit arbiter: fixed-priority or round-robin selection of FIFO heads,
// with per-channel read/write wait gating and a registered access/ack output stage.
module etx_arbiter_rr #(
  parameter int unsigned    N      = 3,
  parameter int unsigned    PW     = 103,
  parameter int unsigned    RR     = 0,
  parameter logic [N-1:0]   RDMASK = N'(3'b010)
) (
  input  logic              tx_lclk_par,
  input  logic              reset,
  input  logic [N-1:0]      fifo_access,
  input  logic [N*PW-1:0]   fifo_packet,
  output logic [N-1:0]      fifo_rd_en,
  output logic              etx_access,
  output logic [PW-1:0]     etx_packet,
  input  logic              etx_rd_wait,
  input  logic              etx_wr_wait,
  input  logic              etx_ack
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  blocked_c;
  logic [N-1:0]  elig_c;
  logic [N-1:0]  grant_c;
  logic [IW-1:0] gidx_c;
  logic          found_c;
  int unsigned   idx_c;
  logic          free_c;
  logic          pop_c;
  logic [PW-1:0] sel_pkt_c;

  logic          etx_access_q, etx_access_d;
  logic [PW-1:0] etx_packet_q, etx_packet_d;
  logic [IW-1:0] ptr_q, ptr_d;

  // Each channel is gated by exactly one of the two wait inputs, chosen by RDMASK.
  always_comb begin
    blocked_c = (RDMASK & {N{etx_rd_wait}}) | (~RDMASK & {N{etx_wr_wait}});
    elig_c    = fifo_access & ~blocked_c;
    free_c    = ~etx_access_q | etx_ack;
  end

  // Search starts at channel 0 (fixed priority) or just past the last winner (round robin).
  always_comb begin
    grant_c = '0;
    gidx_c  = '0;
    found_c = 1'b0;
    idx_c   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx_c = (RR != 0) ? ((32'(ptr_q) + k + 32'd1) % N) : k;
      if (!found_c && elig_c[IW'(idx_c)]) begin
        found_c               = 1'b1;
        grant_c[IW'(idx_c)]   = 1'b1;
        gidx_c                = IW'(idx_c);
      end
    end
  end

  // Pop is combinational so a consumed slot can be refilled in the same cycle.
  always_comb begin
    fifo_rd_en = reset ? '0 : (grant_c & {N{free_c}});
    pop_c      = |fifo_rd_en;
  end

  // One-hot AND-OR packet mux.
  always_comb begin
    sel_pkt_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_c[i]) sel_pkt_c = sel_pkt_c | fifo_packet[i*PW +: PW];
    end
  end

  always_comb begin
    etx_access_d = etx_access_q;
    etx_packet_d = etx_packet_q;
    ptr_d        = ptr_q;
    if (pop_c) begin
      etx_access_d = 1'b1;
      etx_packet_d = sel_pkt_c;
      ptr_d        = gidx_c;
    end else if (etx_ack) begin
      etx_access_d = 1'b0;
    end
  end

  // Pointer resets to N-1 so channel 0 is first in line after reset.
  always_ff @(posedge tx_lclk_par or posedge reset) begin
    if (reset) begin
      etx_access_q <= 1'b0;
      etx_packet_q <= '0;
      ptr_q        <= IW'(N - 1);
    end else begin
      etx_access_q <= etx_access_d;
      etx_packet_q <= etx_packet_d;
      ptr_q        <= ptr_d;
    end
  end

  assign etx_access = etx_access_q;
  assign etx_packet = etx_packet_q;

endmodule

// File: tb/tb_etx_arbiter_rr.sv
// Directed bench for etx_arbiter_rr: fixed-priority, round-robin (N=3 and N=5), stall,
// wait gating and asynchronous reset, each fed by simple head-pointer FIFO models.
module tb_etx_arbiter_rr;

  localparam int unsigned PW = 103;

  logic clk;
  logic rst;
  logic ack;
  logic rd_wait;
  logic wr_wait;
  logic clr;

  int              hd  [3][8];
  int              cnt [3][8];
  logic [7:0]      acc [3];
  logic [8*PW-1:0] pk  [3];
  logic [7:0]      rdv [3];
  logic [2:0]      rd0, rd1;
  logic [4:0]      rd5;
  logic            eacc [3];
  logic [PW-1:0]   epkt [3];

  int n_chk;
  int n_fail;

  function automatic logic [PW-1:0] pkt(input int ch, input int k);
    logic [23:0] v;
    v = {4'(ch), 4'(k), 16'hABCD};
    return PW'(v);
  endfunction

  etx_arbiter_rr #(.N(3), .PW(PW), .RR(0), .RDMASK(3'b010)) u_fp (
    .tx_lclk_par (clk),
    .reset       (rst),
    .fifo_access (acc[0][2:0]),
    .fifo_packet (pk[0][3*PW-1:0]),
    .fifo_rd_en  (rd0),
    .etx_access  (eacc[0]),
    .etx_packet  (epkt[0]),
    .etx_rd_wait (rd_wait),
    .etx_wr_wait (wr_wait),
    .etx_ack     (ack)
  );

  etx_arbiter_rr #(.N(3), .PW(PW), .RR(1), .RDMASK(3'b010)) u_rr3 (
    .tx_lclk_par (clk),
    .reset       (rst),
    .fifo_access (acc[1][2:0]),
    .fifo_packet (pk[1][3*PW-1:0]),
    .fifo_rd_en  (rd1),
    .etx_access  (eacc[1]),
    .etx_packet  (epkt[1]),
    .etx_rd_wait (rd_wait),
    .etx_wr_wait (wr_wait),
    .etx_ack     (ack)
  );

  etx_arbiter_rr #(.N(5), .PW(PW), .RR(1), .RDMASK(5'b00010)) u_rr5 (
    .tx_lclk_par (clk),
    .reset       (rst),
    .fifo_access (acc[2][4:0]),
    .fifo_packet (pk[2][5*PW-1:0]),
    .fifo_rd_en  (rd5),
    .etx_access  (eacc[2]),
    .etx_packet  (epkt[2]),
    .etx_rd_wait (rd_wait),
    .etx_wr_wait (wr_wait),
    .etx_ack     (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rdv[0] = {5'b0, rd0};
    rdv[1] = {5'b0, rd1};
    rdv[2] = {3'b0, rd5};
  end

  // FIFO models: head of channel c is packet number hd, valid while hd < cnt.
  always_comb begin
    for (int s = 0; s < 3; s++) begin
      acc[s] = '0;
      pk[s]  = '0;
      for (int c = 0; c < 8; c++) begin
        acc[s][c]          = (hd[s][c] < cnt[s][c]);
        pk[s][c*PW +: PW]  = pkt(c, hd[s][c]);
      end
    end
  end

  always @(posedge clk) begin
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 8; c++) begin
        if (clr)              hd[s][c] <= 0;
        else if (rdv[s][c])   hd[s][c] <= hd[s][c] + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic zero_cnt();
    for (int s = 0; s < 3; s++)
      for (int c = 0; c < 8; c++) cnt[s][c] = 0;
  endtask

  task automatic load(input int s, input int n0, input int n1, input int n2, input int n3, input int n4);
    zero_cnt();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    cnt[s][0] = n0;
    cnt[s][1] = n1;
    cnt[s][2] = n2;
    cnt[s][3] = n3;
    cnt[s][4] = n4;
  endtask

  task automatic idle();
    zero_cnt();
    ack = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Per cycle: expected pop one-hot, and the packet popped one cycle earlier on the output.
  task automatic expect_seq(input int s, input int len, input int chs[8], input int ks[8]);
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      if (i < len)
        check_eq($sformatf("s%0d_rd_en_%0d", s, i), PW'(rdv[s]), PW'(8'(1 << chs[i])));
      else
        check_eq($sformatf("s%0d_rd_en_idle", s), PW'(rdv[s]), '0);
      if (i > 0) begin
        check_eq($sformatf("s%0d_access_%0d", s, i), PW'(eacc[s]), PW'(1'b1));
        check_eq($sformatf("s%0d_packet_%0d", s, i), epkt[s], pkt(chs[i-1], ks[i-1]));
      end
    end
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst     = 1'b1;
    ack     = 1'b0;
    rd_wait = 1'b0;
    wr_wait = 1'b0;
    clr     = 1'b0;
    zero_cnt();

    // Reset state with a valid head present: no pop, output cleared.
    @(negedge clk);
    load(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check_eq("rst_rd_en", PW'(rdv[0]), '0);
    check_eq("rst_access", PW'(eacc[0]), '0);
    check_eq("rst_packet", epkt[0], '0);
    rst = 1'b0;
    #1;
    check_eq("rst_release_rd_en", PW'(rdv[0]), PW'(8'b001));
    idle();

    // Fixed priority drains ch0, ch1, ch2 back to back.
    ack = 1'b1;
    load(0, 2, 2, 2, 0, 0);
    expect_seq(0, 6, '{0, 0, 1, 1, 2, 2, 0, 0}, '{0, 1, 0, 1, 0, 1, 0, 0});
    idle();

    // Round robin interleaves, starting at ch0 after reset.
    pulse_reset();
    ack = 1'b1;
    load(1, 2, 2, 2, 0, 0);
    expect_seq(1, 6, '{0, 1, 2, 0, 1, 2, 0, 0}, '{0, 0, 0, 1, 1, 1, 0, 0});
    idle();

    // Output stall: held packet stays and no pops until ack returns.
    ack = 1'b0;
    load(0, 3, 0, 0, 0, 0);
    @(negedge clk);
    check_eq("stall_first_pop", PW'(rdv[0]), PW'(8'b001));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("stall_rd_en_%0d", i), PW'(rdv[0]), '0);
      check_eq($sformatf("stall_access_%0d", i), PW'(eacc[0]), PW'(1'b1));
      check_eq($sformatf("stall_packet_%0d", i), epkt[0], pkt(0, 0));
    end
    ack = 1'b1;
    #1;
    check_eq("stall_ack_pop", PW'(rdv[0]), PW'(8'b001));
    @(negedge clk);
    check_eq("stall_next_packet", epkt[0], pkt(0, 1));
    check_eq("stall_next_access", PW'(eacc[0]), PW'(1'b1));
    idle();

    // Write wait blocks ch0 (write class) but not ch1 (read class).
    ack     = 1'b1;
    wr_wait = 1'b1;
    load(0, 1, 1, 0, 0, 0);
    @(negedge clk);
    check_eq("wait_grant_ch1", PW'(rdv[0]), PW'(8'b010));
    @(negedge clk);
    check_eq("wait_ch0_blocked", PW'(rdv[0]), '0);
    check_eq("wait_packet_ch1", epkt[0], pkt(1, 0));
    wr_wait = 1'b0;
    #1;
    check_eq("wait_release_ch0", PW'(rdv[0]), PW'(8'b001));
    @(negedge clk);
    check_eq("wait_packet_ch0", epkt[0], pkt(0, 0));
    idle();

    // Asynchronous reset mid-transfer drops the held packet immediately.
    ack = 1'b0;
    load(0, 2, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check_eq("areset_pre_low16", PW'(epkt[0][15:0]), PW'(16'hABCD));
    check_eq("areset_pre_access", PW'(eacc[0]), PW'(1'b1));
    #2;
    rst = 1'b1;
    #1;
    check_eq("areset_access", PW'(eacc[0]), '0);
    check_eq("areset_packet", epkt[0], '0);
    check_eq("areset_rd_en", PW'(rdv[0]), '0);
    @(negedge clk);
    check_eq("areset_hold_rd_en", PW'(rdv[0]), '0);
    check_eq("areset_hold_access", PW'(eacc[0]), '0);
    rst = 1'b0;
    #1;
    check_eq("areset_release_rd_en", PW'(rdv[0]), PW'(8'b001));
    @(negedge clk);
    check_eq("areset_next_packet", epkt[0], pkt(0, 1));
    idle();

    // N=5 round robin wraps from ch4 back to ch1.
    pulse_reset();
    ack = 1'b1;
    load(2, 0, 2, 0, 0, 2);
    expect_seq(2, 4, '{1, 4, 1, 4, 0, 0, 0, 0}, '{0, 0, 1, 1, 0, 0, 0, 0});
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/etx_arbiter_rr.md
Name: etx_arbiter_rr

Overview:
- Parametrised N-channel eMesh transmit arbiter. Successor to the fixed three-input TX arbiter.
- Takes N first-word-fall-through FIFO outputs, for example host writes, read requests, read responses, and future DMA/mailbox channels.
- Selects one channel per cycle using either fixed-priority or round-robin mode, with per-channel wait-class gating.
- Registers the winning packet towards the TX protocol block, using an access/ack handshake that sustains one packet per cycle.

Parameters:
- N, 3: number of input channels (2..8).
- PW, 103: packet width without access. Packing, MSB to LSB: write[1], datamode[2], ctrlmode[4], dstaddr[32], data[32], srcaddr[32].
- RR, 0: arbitration mode. 0 = fixed priority, channel 0 highest. 1 = round robin.
- RDMASK, 3'b010: N-bit mask. Bit i = 1 means channel i is gated by etx_rd_wait; 0 means gated by etx_wr_wait.

Ports:
- tx_lclk_par  in  1  transmit parallel clock; only clock.
- reset  in  1  asynchronous, active-high reset.
- fifo_access  in  N  per-channel "FIFO head valid".
- fifo_packet  in  N*PW  per-channel head packet; channel i occupies [i*PW +: PW].
- fifo_rd_en  out  N  per-channel pop, one-hot or zero.
- etx_access  out  1  output packet valid.
- etx_packet  out  PW  registered output packet.
- etx_rd_wait  in  1  blocks channels whose RDMASK bit is 1.
- etx_wr_wait  in  1  blocks channels whose RDMASK bit is 0.
- etx_ack  in  1  TX protocol has consumed etx_packet this cycle.

Behaviour:
- Eligibility: elig[i] = fifo_access[i] & ~(RDMASK[i] ? etx_rd_wait : etx_wr_wait).
- Slot free: free = ~etx_access | etx_ack.
- Grant (combinational, one-hot or zero):
  - RR=0: lowest-index eligible channel.
  - RR=1: first eligible channel at index ptr+1, ptr+2, … modulo N, where ptr is the last granted index. Wrap from N-1 to 0.
- Pop: fifo_rd_en = grant & {N{free}}. Never more than one bit set. Never asserted when free=0.
- Output register on posedge tx_lclk_par:
  - If any fifo_rd_en: etx_packet <= the granted channel's packet and etx_access <= 1.
  - Else if etx_ack: etx_access <= 0 and etx_packet holds its value.
  - Else: both hold.
- Latency: pop in cycle n makes the packet visible on etx_access/etx_packet in cycle n+1.
- Throughput: with etx_ack held high and eligible input, one packet per cycle with no bubble.
- Pointer update: ptr <= granted index only on a cycle where a pop occurs. It is unchanged when the output is stalled. It is unused when RR=0.
- Wait assertion while etx_access=1 does not withdraw the held packet. Waits affect only new grants.
- etx_ack while etx_access=0 is ignored: no state change beyond normal arbitration.
- Simultaneous etx_ack and pop: the new packet replaces the old one and etx_access stays 1.
- Reset (asynchronous, any time, including mid-transfer):
  - etx_access=0, etx_packet=0, ptr=N-1 so channel 0 wins first in RR mode.
  - fifo_rd_en is 0 while reset is asserted.
  - An in-flight packet is dropped.
- The FIFO must present the next head, or deassert fifo_access, in the cycle after a pop.

Test Plan:
- RR=0, all three channels hold 2 packets each, no waits, etx_ack=1 constantly -> etx_packet order ch0,ch0,ch1,ch1,ch2,ch2 on 6 consecutive cycles; fifo_rd_en one-hot each cycle.
- RR=1, same stimulus -> order ch0,ch1,ch2,ch0,ch1,ch2. After reset, the first grant is ch0.
- Channel 0 valid with etx_access=1 and etx_ack=0 for 5 cycles -> fifo_rd_en=0 and etx_packet stable for 5 cycles. Ack in cycle 6 -> pop in cycle 6, new packet in cycle 7.
- etx_wr_wait=1 with ch0 and ch1 valid (RDMASK=010) -> only ch1 is granted. Deassert the wait -> ch0 is granted next in RR=0.
- Assert reset asynchronously while etx_access=1 with packet 0x…ABCD -> etx_access=0 and etx_packet=0 immediately, before the next clock edge. No pops until reset is released.
- N=5, RR=1, only ch4 and ch1 valid with ptr=4 -> grant order ch1,ch4,ch1,ch4. Confirms wrap-around.
